xbar_rr_nxm: RTL

- Parametrised MASTERS x SLAVES crossbar: next generation of the fixed 4-port host/agent crossbar.
- Routes each master request to a slave selected by the top address bits.
- Each slave has its own round-robin arbiter and transaction FSM, so transfers to different slaves proceed concurrently.
- Sits between host-side agents and slave register blocks, using the same req/cmd/ack/resp handshake.

---
 rtl/xbar_pkg.sv | 32 +++
 rtl/xbar_rr_slot.sv | 140 ++++++++++++++
 rtl/xbar_rr_nxm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the round-robin N x M crossbar.
//   state_e     : per-slot transaction state (IDLE, BUSY, RESP)
//   cmd_e       : master command encoding (read = 0, write = 1)
//   DECERR_DATA : read data returned by the decode-error responder
//   sel_idx()   : extracts the slave-select field from the top address bits
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    // Wide enough for any supported DW; users slice [DW-1:0].
    localparam logic [63:0] DECERR_DATA = '1;

    // Slave index = addr[aw-1 -: sel_w]; addr is zero-extended to 64 bits.
    function automatic int unsigned sel_idx(input logic [63:0] addr,
                                            input int unsigned aw,
                                            input int unsigned sel_w);
        logic [63:0] sh;
        sh = addr >> (aw - sel_w);
        sh = sh & ((64'd1 << sel_w) - 64'd1);
        return sh[31:0];
    endfunction

endpackage

// File: rtl/xbar_rr_slot.sv
// One crossbar slot: round-robin arbiter, IDLE/BUSY/RESP FSM and capture
// registers for a single slave (or for the decode-error responder).
// Ports:
//   clk_i, reset_ni      clock, asynchronous active-low reset
//   req_i                per-master requests already decoded to this slot
//   cmd_i/addr_i/wdata_i flattened per-master command, address, write data
//   resp_i               per-master read-data acceptance
//   ack_o                one-cycle ack to the granted master
//   busy_o               one-hot of the master being served while BUSY
//   rsel_o, rdata_o      one-hot owner and value of captured read data (RESP)
//   s_req_o ... s_ack_i  slave-side handshake
module xbar_rr_slot
    import xbar_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MASTERS = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [MASTERS-1:0]    req_i,
    input  logic [MASTERS-1:0]    cmd_i,
    input  logic [MASTERS*AW-1:0] addr_i,
    input  logic [MASTERS*DW-1:0] wdata_i,
    input  logic [MASTERS-1:0]    resp_i,
    output logic [MASTERS-1:0]    ack_o,
    output logic [MASTERS-1:0]    busy_o,
    output logic [MASTERS-1:0]    rsel_o,
    output logic [DW-1:0]         rdata_o,
    output logic                  s_req_o,
    output logic                  s_cmd_o,
    output logic [AW-1:0]         s_addr_o,
    output logic [DW-1:0]         s_wdata_o,
    input  logic [DW-1:0]         s_rdata_i,
    input  logic                  s_ack_i
);

    localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    state_e              state_q, state_d;
    cmd_e                cmd_q, cmd_d;
    logic [MW-1:0]       grant_q, grant_d, ptr_q, ptr_d, pick;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [MASTERS-1:0]  ack_q, ack_d, elig, grant_oh;
    logic                found;

    // A master being acked this cycle still has req high; it only counts as
    // a new request from the following cycle on.
    assign elig = req_i & ~ack_q;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < MASTERS; i++) begin
            if (!found && elig[MW'((32'(ptr_q) + i) % MASTERS)]) begin
                found = 1'b1;
                pick  = MW'((32'(ptr_q) + i) % MASTERS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    cmd_d   = cmd_e'(cmd_i[pick]);
                    addr_d  = addr_i[pick*AW +: AW];
                    wdata_d = wdata_i[pick*DW +: DW];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ack_i) begin
                    ack_d[grant_q] = 1'b1;
                    ptr_d          = MW'((32'(grant_q) + 32'd1) % MASTERS);
                    if (cmd_q == CMD_READ) begin
                        rdata_d = s_rdata_i;
                        state_d = RESP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                if (resp_i[grant_q]) begin
                    rdata_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cmd_q   <= CMD_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

    assign busy_o    = (state_q == BUSY) ? grant_oh : '0;
    assign rsel_o    = (state_q == RESP) ? grant_oh : '0;
    assign rdata_o   = rdata_q;
    assign ack_o     = ack_q;
    assign s_req_o   = (state_q == BUSY);
    assign s_cmd_o   = cmd_q;
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;

endmodule

// File: rtl/xbar_rr_nxm.sv
// MASTERS x SLAVES crossbar with a round-robin arbiter and FSM per slave.
// Slave index = m_addr_i[AW-1 -: $clog2(SLAVES)].
// Optional macro XBAR_DECERR_EN: out-of-range indices are served by an
// internal error responder (reads return all ones, writes are dropped);
// without it such requests are never granted.
// Ports (per-master / per-slave vectors are flattened, index 0 in the LSBs):
//   clk_i, reset_ni                       clock, async active-low reset
//   m_req_i, m_cmd_i, m_addr_i, m_wdata_i master request side
//   m_resp_i, m_rdata_o, m_ack_o          master response side
//   s_req_o, s_cmd_o, s_addr_o, s_wdata_o slave request side
//   s_rdata_i, s_ack_i                    slave completion side
module xbar_rr_nxm
    import xbar_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MASTERS = 4,
    parameter int SLAVES  = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [MASTERS-1:0]    m_req_i,
    input  logic [MASTERS-1:0]    m_cmd_i,
    input  logic [MASTERS*AW-1:0] m_addr_i,
    input  logic [MASTERS*DW-1:0] m_wdata_i,
    input  logic [MASTERS-1:0]    m_resp_i,
    output logic [MASTERS*DW-1:0] m_rdata_o,
    output logic [MASTERS-1:0]    m_ack_o,
    output logic [SLAVES-1:0]     s_req_o,
    output logic [SLAVES-1:0]     s_cmd_o,
    output logic [SLAVES*AW-1:0]  s_addr_o,
    output logic [SLAVES*DW-1:0]  s_wdata_o,
    input  logic [SLAVES*DW-1:0]  s_rdata_i,
    input  logic [SLAVES-1:0]     s_ack_i
);

    localparam int SEL_W = $clog2(SLAVES);

    int unsigned         sel [MASTERS];
    logic [MASTERS-1:0]  slot_req   [SLAVES];
    logic [MASTERS-1:0]  slot_ack   [SLAVES];
    logic [MASTERS-1:0]  slot_busy  [SLAVES];
    logic [MASTERS-1:0]  slot_rsel  [SLAVES];
    logic [DW-1:0]       slot_rdata [SLAVES];
    logic [MASTERS-1:0]  busy_any, err_ack, err_busy, err_rsel;
    logic [DW-1:0]       err_rdata;

    always_comb begin
        for (int unsigned m = 0; m < MASTERS; m++) begin
            sel[m] = sel_idx(64'(m_addr_i[m*AW +: AW]), AW, SEL_W);
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < SLAVES; s++) begin
            slot_req[s] = '0;
            for (int unsigned m = 0; m < MASTERS; m++) begin
                slot_req[s][m] = m_req_i[m] && !busy_any[m] && (sel[m] == s);
            end
        end
    end

    for (genvar s = 0; s < SLAVES; s++) begin : g_slot
        xbar_rr_slot #(.DW(DW), .AW(AW), .MASTERS(MASTERS)) u_slot (
            .clk_i     (clk_i),
            .reset_ni  (reset_ni),
            .req_i     (slot_req[s]),
            .cmd_i     (m_cmd_i),
            .addr_i    (m_addr_i),
            .wdata_i   (m_wdata_i),
            .resp_i    (m_resp_i),
            .ack_o     (slot_ack[s]),
            .busy_o    (slot_busy[s]),
            .rsel_o    (slot_rsel[s]),
            .rdata_o   (slot_rdata[s]),
            .s_req_o   (s_req_o[s]),
            .s_cmd_o   (s_cmd_o[s]),
            .s_addr_o  (s_addr_o[s*AW +: AW]),
            .s_wdata_o (s_wdata_o[s*DW +: DW]),
            .s_rdata_i (s_rdata_i[s*DW +: DW]),
            .s_ack_i   (s_ack_i[s])
        );
    end

`ifdef XBAR_DECERR_EN
    logic [MASTERS-1:0] err_req;
    logic               err_s_req, err_s_cmd;
    logic [AW-1:0]      err_s_addr;
    logic [DW-1:0]      err_s_wdata;

    always_comb begin
        err_req = '0;
        for (int unsigned m = 0; m < MASTERS; m++) begin
            err_req[m] = m_req_i[m] && !busy_any[m] && (sel[m] >= SLAVES);
        end
    end

    // Error responder: a slot whose slave always acks immediately.
    xbar_rr_slot #(.DW(DW), .AW(AW), .MASTERS(MASTERS)) u_decerr (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .req_i     (err_req),
        .cmd_i     (m_cmd_i),
        .addr_i    (m_addr_i),
        .wdata_i   (m_wdata_i),
        .resp_i    (m_resp_i),
        .ack_o     (err_ack),
        .busy_o    (err_busy),
        .rsel_o    (err_rsel),
        .rdata_o   (err_rdata),
        .s_req_o   (err_s_req),
        .s_cmd_o   (err_s_cmd),
        .s_addr_o  (err_s_addr),
        .s_wdata_o (err_s_wdata),
        .s_rdata_i (DECERR_DATA[DW-1:0]),
        .s_ack_i   (1'b1)
    );
`else
    assign err_ack   = '0;
    assign err_busy  = '0;
    assign err_rsel  = '0;
    assign err_rdata = '0;
`endif

    always_comb begin
        m_ack_o   = err_ack;
        busy_any  = err_busy;
        m_rdata_o = '0;
        for (int unsigned s = 0; s < SLAVES; s++) begin
            m_ack_o  = m_ack_o | slot_ack[s];
            busy_any = busy_any | slot_busy[s];
        end
        for (int unsigned m = 0; m < MASTERS; m++) begin
            if (err_rsel[m]) m_rdata_o[m*DW +: DW] = err_rdata;
            for (int unsigned s = 0; s < SLAVES; s++) begin
                if (slot_rsel[s][m]) m_rdata_o[m*DW +: DW] = m_rdata_o[m*DW +: DW] | slot_rdata[s];
            end
        end
    end

endmodule
